// File: rtl/seg_scan_pkg.sv
// Shared segment codes (active-low {dp,g,f,e,d,c,b,a}), digit count and default scan divider.
package seg_scan_pkg;

  localparam int NUM_DIGITS  = 8;
  localparam int DIV_DEFAULT = 100000;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Index of the highest nonzero nibble; 0 when the word is all zero so digit 0 always shows.
  function automatic logic [2:0] top_nonzero(input logic [31:0] w);
    logic [2:0] t;
    t = 3'd0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (w[4*k +: 4] != 4'h0) t = 3'(k);
    end
    return t;
  endfunction

endpackage

// File: rtl/seg_scan_hex_decode.sv
// Combinational hex nibble to active-low cathode pattern, decimal point held off.
module seg_hex_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// 8-digit common-anode scanner with tear-free frame-boundary commit; outputs registered 1 cycle after tick.
// No backpressure: writes are always accepted, last write per frame wins. SEG_BLANK_EN adds leading-zero blanking.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seg_data,
  input  logic        seg_we,
  output logic [7:0]  an,
  output logic [7:0]  cat,
  output logic        frame_done
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] prescaler;
  logic [2:0]       idx;
  logic [31:0]      active;
  logic [31:0]      pending_data;
  logic             pending;
  logic             tick;
  logic             boundary;
  logic [3:0]       nibble;
  logic [7:0]       seg_code;
  logic [7:0]       an_nxt;
  logic [7:0]       cat_nxt;

  assign tick     = (prescaler == CNT_W'(DIV - 1));
  assign boundary = tick && (idx == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      idx       <= 3'd0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) idx <= idx + 3'd1;
    end
  end

  // Shadow register: active only changes on the frame boundary, so a frame never mixes two words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active       <= 32'h0;
      pending_data <= 32'h0;
      pending      <= 1'b0;
    end else if (boundary) begin
      pending <= 1'b0;
      if (seg_we)       active <= seg_data;
      else if (pending) active <= pending_data;
    end else if (seg_we) begin
      pending_data <= seg_data;
      pending      <= 1'b1;
    end
  end

  assign nibble = active[{idx, 2'b00} +: 4];

  seg_hex_decode u_decode (
    .nibble (nibble),
    .seg    (seg_code)
  );

`ifdef SEG_BLANK_EN
  logic [2:0] top_digit;

  assign top_digit = top_nonzero(active);

  always_comb begin
    an_nxt  = ~(8'b1 << idx);
    cat_nxt = seg_code;
    if (idx > top_digit) begin
      an_nxt  = 8'hFF;
      cat_nxt = SEG_BLANK;
    end
  end
`else
  assign an_nxt  = ~(8'b1 << idx);
  assign cat_nxt = seg_code;
`endif

  // an and cat share one register stage so anode and cathode switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 8'hFF;
      cat        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      cat        <= cat_nxt;
      frame_done <= boundary;
    end
  end

endmodule
